// File: rtl/microwave_pkg.sv
// Shared types and constants for the cook sequencer and its duty-cycle generator.
package microwave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COOK,
        ST_PAUSE,
        ST_DONE
    } state_t;

    // BCD {minutes, tens of seconds, seconds}
    typedef logic [11:0] bcd_time_t;

    localparam int POWER_MAX   = 10;
    localparam int DUTY_WINDOW = 10;
    localparam int MAX_STAGES  = 4;

    function automatic logic [3:0] clamp_power(input logic [3:0] p);
        return (p > 4'(POWER_MAX)) ? 4'(POWER_MAX) : p;
    endfunction

endpackage

// File: rtl/cook_sequencer_if.sv
// Programming port and countdown-timer handshake shared by the sequencer and its surroundings.
interface cook_sequencer_if;
    logic                     prog_we;
    logic [1:0]               prog_stage;
    microwave_pkg::bcd_time_t prog_time;
    logic [3:0]               prog_power;
    logic                     tmr_zero;
    microwave_pkg::bcd_time_t tmr_data;
    logic                     tmr_loadn;
    logic                     tmr_en;

    modport master (
        input  prog_we, prog_stage, prog_time, prog_power, tmr_zero,
        output tmr_data, tmr_loadn, tmr_en
    );

    modport slave (
        output prog_we, prog_stage, prog_time, prog_power, tmr_zero,
        input  tmr_data, tmr_loadn, tmr_en
    );
endinterface

// File: rtl/cook_sequencer_duty_gen.sv
// Power-level duty cycle: a phase counter over a 10 s window compared against the power level.
module duty_gen
    import microwave_pkg::*;
(
    input  logic       clk,
    input  logic       clrn,
    input  logic       clear,
    input  logic       adv,
    input  logic [3:0] power,
    output logic       mag_raw
);

    logic [3:0] phase;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            phase <= '0;
        end else if (clear) begin
            phase <= '0;
        end else if (adv) begin
            phase <= (phase == 4'(DUTY_WINDOW - 1)) ? 4'd0 : phase + 4'd1;
        end
    end

    // phase and power are both registers, so this compare cannot glitch between ticks
    assign mag_raw = (phase < power);

endmodule

// File: rtl/cook_sequencer.sv
// Multi-stage cook controller: programs stages, loads the timer per stage, duty-cycles the magnetron.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  ST_IDLE  | programmable; waits for start with door shut
//  ST_LOAD  | tmr_loadn low for this single clock, duty phase cleared
//  ST_COOK  | timer running, mag follows duty compare
//  ST_PAUSE | door open or stop pressed; timer and phase frozen
//  ST_DONE  | beep for BEEP_SECS seconds, then idle
module cook_sequencer
    import microwave_pkg::*;
#(
    parameter int NSTAGES   = 2,
    parameter int BEEP_SECS = 3
) (
    input  logic                    clk,
    input  logic                    clrn,
    input  logic                    tick_1hz,
    input  logic                    startn,
    input  logic                    stopn,
    input  logic                    door_closed,
    cook_sequencer_if.master        bus,
    output logic                    mag,
    output logic [1:0]              stage,
    output logic                    busy,
    output logic                    beep
);

    state_t     state;
    bcd_time_t  stage_time  [MAX_STAGES];
    logic [3:0] stage_power [MAX_STAGES];
    bcd_time_t  tmr_data_r;
    logic       tmr_loadn_r;
    logic       tmr_en_r;
    logic [7:0] beep_cnt;
    logic       start_q;
    logic       stop_q;
    logic       start_fall;
    logic       stop_fall;
    logic       mag_raw;
    logic       duty_adv;
    logic       first_found;
    logic [1:0] first_idx;
    logic       next_found;
    logic [1:0] next_idx;

    // start is ignored while stop is held
    assign start_fall = start_q & ~startn & stopn;
    assign stop_fall  = stop_q & ~stopn;

    assign bus.tmr_data  = tmr_data_r;
    assign bus.tmr_loadn = tmr_loadn_r;
    assign bus.tmr_en    = tmr_en_r;

    // descending scan so the lowest qualifying index wins
    always_comb begin
        first_found = 1'b0;
        first_idx   = 2'd0;
        next_found  = 1'b0;
        next_idx    = 2'd0;
        for (int i = MAX_STAGES - 1; i >= 0; i--) begin
            if (i < NSTAGES && stage_time[i] != '0 && stage_power[i] != 4'd0) begin
                first_found = 1'b1;
                first_idx   = 2'(i);
                if (2'(i) > stage) begin
                    next_found = 1'b1;
                    next_idx   = 2'(i);
                end
            end
        end
    end

    assign duty_adv = (state == ST_COOK) && tick_1hz && door_closed && !stop_fall && !bus.tmr_zero;

    duty_gen u_duty_gen (
        .clk     (clk),
        .clrn    (clrn),
        .clear   (state == ST_LOAD),
        .adv     (duty_adv),
        .power   (stage_power[stage]),
        .mag_raw (mag_raw)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= ST_IDLE;
            for (int i = 0; i < MAX_STAGES; i++) begin
                stage_time[i]  <= '0;
                stage_power[i] <= 4'(POWER_MAX);
            end
            tmr_data_r  <= '0;
            tmr_loadn_r <= 1'b1;
            tmr_en_r    <= 1'b0;
            mag         <= 1'b0;
            stage       <= 2'd0;
            busy        <= 1'b0;
            beep        <= 1'b0;
            beep_cnt    <= '0;
            start_q     <= 1'b1;
            stop_q      <= 1'b1;
        end else begin
            start_q <= startn;
            stop_q  <= stopn;
            case (state)
                ST_IDLE: begin
                    tmr_loadn_r <= 1'b1;
                    tmr_en_r    <= 1'b0;
                    mag         <= 1'b0;
                    busy        <= 1'b0;
                    beep        <= 1'b0;
                    if (bus.prog_we && int'(bus.prog_stage) < NSTAGES) begin
                        stage_time[bus.prog_stage]  <= bus.prog_time;
                        stage_power[bus.prog_stage] <= clamp_power(bus.prog_power);
                    end
                    if (start_fall && door_closed && first_found) begin
                        // load pulse is issued on entry so it lines up exactly with ST_LOAD
                        stage       <= first_idx;
                        tmr_data_r  <= stage_time[first_idx];
                        tmr_loadn_r <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tmr_loadn_r <= 1'b1;
                    tmr_en_r    <= 1'b1;
                    mag         <= 1'b0;
                    state       <= ST_COOK;
                end
                ST_COOK: begin
                    if (!door_closed || stop_fall) begin
                        mag      <= 1'b0;
                        tmr_en_r <= 1'b0;
                        state    <= ST_PAUSE;
                    end else if (bus.tmr_zero) begin
                        mag      <= 1'b0;
                        tmr_en_r <= 1'b0;
                        if (next_found) begin
                            stage       <= next_idx;
                            tmr_data_r  <= stage_time[next_idx];
                            tmr_loadn_r <= 1'b0;
                            state       <= ST_LOAD;
                        end else begin
                            busy     <= 1'b0;
                            beep     <= 1'b1;
                            beep_cnt <= 8'(BEEP_SECS);
                            state    <= ST_DONE;
                        end
                    end else begin
                        mag      <= mag_raw;
                        tmr_en_r <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    mag      <= 1'b0;
                    tmr_en_r <= 1'b0;
                    if (stop_fall) begin
                        stage <= 2'd0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (start_fall && door_closed) begin
                        tmr_en_r <= 1'b1;
                        state    <= ST_COOK;
                    end
                end
                ST_DONE: begin
                    mag      <= 1'b0;
                    tmr_en_r <= 1'b0;
                    if (start_fall || stop_fall) begin
                        beep  <= 1'b0;
                        stage <= 2'd0;
                        state <= ST_IDLE;
                    end else if (tick_1hz) begin
                        if (beep_cnt <= 8'd1) begin
                            beep  <= 1'b0;
                            stage <= 2'd0;
                            state <= ST_IDLE;
                        end else begin
                            beep_cnt <= beep_cnt - 8'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cook_sequencer.sv
// Directed bench for cook_sequencer; timer loads are checked against a queue of expected values.
module tb_cook_sequencer;
    import microwave_pkg::*;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       startn = 1'b1;
    logic       stopn = 1'b1;
    logic       door_closed = 1'b1;
    logic       mag;
    logic [1:0] stage;
    logic       busy;
    logic       beep;

    int         n_checks = 0;
    int         n_fail = 0;
    bcd_time_t  load_q[$];
    logic       prev_loadn = 1'b1;

    cook_sequencer_if bus ();

    cook_sequencer #(.NSTAGES(2), .BEEP_SECS(3)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .tick_1hz    (tick_1hz),
        .startn      (startn),
        .stopn       (stopn),
        .door_closed (door_closed),
        .bus         (bus.master),
        .mag         (mag),
        .stage       (stage),
        .busy        (busy),
        .beep        (beep)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // every load pulse must be expected, one clock wide, and carry the queued time
    always @(negedge clk) begin
        if (clrn === 1'b1 && bus.tmr_loadn === 1'b0) begin
            chk("load_expected", 32'(load_q.size() > 0), 1);
            chk("load_width", 32'(prev_loadn), 1);
            if (load_q.size() > 0) chk("load_data", 32'(bus.tmr_data), 32'(load_q.pop_front()));
        end
        prev_loadn = bus.tmr_loadn;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
    endtask

    task automatic press_start();
        startn = 1'b0;
        @(negedge clk);
        startn = 1'b1;
    endtask

    task automatic press_stop();
        stopn = 1'b0;
        @(negedge clk);
        stopn = 1'b1;
    endtask

    task automatic zero_pulse();
        bus.tmr_zero = 1'b1;
        @(negedge clk);
        bus.tmr_zero = 1'b0;
    endtask

    task automatic prog(input logic [1:0] idx, input logic [11:0] t, input logic [3:0] p);
        bus.prog_we    = 1'b1;
        bus.prog_stage = idx;
        bus.prog_time  = t;
        bus.prog_power = p;
        @(negedge clk);
        bus.prog_we    = 1'b0;
    endtask

    task automatic stop_to_idle();
        press_stop();
        step(1);
        press_stop();
        step(1);
    endtask

    initial begin
        int ph;
        int highs;
        bus.prog_we    = 1'b0;
        bus.prog_stage = 2'd0;
        bus.prog_time  = '0;
        bus.prog_power = 4'd0;
        bus.tmr_zero   = 1'b0;
        step(3);
        chk("rst_loadn", 32'(bus.tmr_loadn), 1);
        chk("rst_en", 32'(bus.tmr_en), 0);
        chk("rst_busy", 32'(busy), 0);
        clrn = 1'b1;
        step(2);

        // 1:30 at full power
        prog(2'd0, 12'h130, 4'd10);
        load_q.push_back(12'h130);
        press_start();
        chk("t1_busy_load", 32'(busy), 1);
        step(2);
        chk("t1_en", 32'(bus.tmr_en), 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            step(1);
            chk("t1_mag_steady", 32'(mag), 1);
        end
        chk("t1_stage", 32'(stage), 0);
        stop_to_idle();
        chk("t1_idle_busy", 32'(busy), 0);

        // 0:20 at power 3, then done beep
        prog(2'd0, 12'h020, 4'd3);
        load_q.push_back(12'h020);
        press_start();
        step(2);
        ph = 0;
        highs = 0;
        chk("t2_mag_phase0", 32'(mag), 1);
        for (int k = 0; k < 10; k++) begin
            tick();
            step(1);
            ph = (ph + 1) % 10;
            chk("t2_duty", 32'(mag), 32'(ph < 3));
            if (mag === 1'b1) highs++;
        end
        chk("t2_duty_count", 32'(highs), 3);
        zero_pulse();
        chk("t2_done_beep", 32'(beep), 1);
        chk("t2_done_busy", 32'(busy), 0);
        chk("t2_done_mag", 32'(mag), 0);
        chk("t2_done_en", 32'(bus.tmr_en), 0);
        tick();
        tick();
        chk("t2_beep_held", 32'(beep), 1);
        tick();
        chk("t2_beep_end", 32'(beep), 0);
        step(1);
        chk("t2_idle_busy", 32'(busy), 0);

        // two stages, second at 50 %; writes during cook are ignored
        prog(2'd0, 12'h010, 4'd10);
        prog(2'd1, 12'h005, 4'd5);
        load_q.push_back(12'h010);
        press_start();
        step(2);
        prog(2'd1, 12'h099, 4'd10);
        load_q.push_back(12'h005);
        zero_pulse();
        chk("t3_stage1", 32'(stage), 1);
        chk("t3_mag_load", 32'(mag), 0);
        step(2);
        chk("t3_mag_phase0", 32'(mag), 1);
        highs = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            step(1);
            if (mag === 1'b1) highs++;
        end
        chk("t3_duty_count", 32'(highs), 5);
        stop_to_idle();
        chk("t3_idle_stage", 32'(stage), 0);

        // door opens mid-cook, resume without reload
        load_q.push_back(12'h010);
        press_start();
        step(2);
        chk("t4_mag_on", 32'(mag), 1);
        door_closed = 1'b0;
        step(1);
        chk("t4_door_mag", 32'(mag), 0);
        chk("t4_door_en", 32'(bus.tmr_en), 0);
        chk("t4_pause_busy", 32'(busy), 1);
        door_closed = 1'b1;
        step(1);
        press_start();
        chk("t4_resume_en", 32'(bus.tmr_en), 1);
        step(1);
        chk("t4_resume_mag", 32'(mag), 1);
        stop_to_idle();

        // zero-time stage skipped; over-range power clamps to continuous
        prog(2'd0, 12'h000, 4'd10);
        prog(2'd1, 12'h007, 4'hF);
        load_q.push_back(12'h007);
        press_start();
        chk("t5_first_stage1", 32'(stage), 1);
        step(2);
        for (int k = 0; k < 10; k++) begin
            tick();
            step(1);
            chk("t5_clamp_mag", 32'(mag), 1);
        end
        stop_to_idle();
        prog(2'd1, 12'h000, 4'd5);
        press_start();
        chk("t5_none_busy", 32'(busy), 0);
        step(1);
        chk("t5_none_busy2", 32'(busy), 0);

        // stop beats tmr_zero; then async reset mid-cook
        prog(2'd0, 12'h020, 4'd10);
        prog(2'd1, 12'h005, 4'd5);
        load_q.push_back(12'h020);
        press_start();
        step(2);
        bus.tmr_zero = 1'b1;
        stopn = 1'b0;
        @(negedge clk);
        bus.tmr_zero = 1'b0;
        stopn = 1'b1;
        chk("t6_pause_busy", 32'(busy), 1);
        chk("t6_pause_stage", 32'(stage), 0);
        chk("t6_pause_en", 32'(bus.tmr_en), 0);
        step(1);
        press_start();
        chk("t6_resume_en", 32'(bus.tmr_en), 1);
        step(1);
        chk("t6_mag_on", 32'(mag), 1);
        clrn = 1'b0;
        #1;
        chk("t6_rst_mag", 32'(mag), 0);
        chk("t6_rst_en", 32'(bus.tmr_en), 0);
        chk("t6_rst_loadn", 32'(bus.tmr_loadn), 1);
        chk("t6_rst_data", 32'(bus.tmr_data), 0);
        chk("t6_rst_stage", 32'(stage), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_beep", 32'(beep), 0);
        @(negedge clk);
        clrn = 1'b1;
        step(1);
        press_start();
        chk("t6_regs_cleared", 32'(busy), 0);
        step(2);

        chk("scoreboard_drained", 32'(load_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
